// File: rtl/matmul_pkg.sv
// Shared widths, FSM state encoding and operand payload for the matmul dot-product lanes.
package matmul_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/operand_fifo.sv
// Parameterised synchronous FIFO with registered full/empty/count; head is read combinationally.
module operand_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_n;

  // Pushes while full and pops while empty are dropped here as well as upstream.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    count_n = count + CW'(do_push) - CW'(do_pop);
  end

  assign rdata_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/matmul_dot_issuer.sv
// Issues buffered operand pairs to a multiplier over stb/ack and accumulates LEN products per dot.
// Optional DOTP_SATURATE_EN clamps the accumulator and flags saturation in dot_sat.
module matmul_dot_issuer
  import matmul_pkg::*;
#(
  parameter int unsigned LEN     = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [OP_W-1:0]  in_a,
  input  logic signed [OP_W-1:0]  in_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OP_W-1:0]  num1,
  output logic signed [OP_W-1:0]  num2,
  output logic                    num1_stb,
  output logic                    num2_stb,
  input  logic                    num1_ack,
  input  logic                    num2_ack,
  input  logic                    result_ack,
  input  logic signed [PROD_W-1:0] result,
  output logic signed [ACC_W-1:0] dot,
  output logic                    dot_valid,
  input  logic                    dot_ready,
  output logic                    dot_sat,
  output logic                    err_timeout,
  output logic                    busy
);

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned FC_W  = $clog2(DEPTH) + 1;

`ifdef DOTP_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  state_t                  state_q, state_n;
  logic signed [ACC_W-1:0] acc_q, acc_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  logic [TO_W-1:0]         tcnt_q, tcnt_n;
  logic                    sat_q, sat_n;

  logic signed [OP_W-1:0]  num1_n, num2_n;
  logic signed [ACC_W-1:0] dot_n;
  logic                    dot_valid_n, dot_sat_n, err_n, stb_n, busy_n, in_ready_n;

  logic signed [ACC_W-1:0] ext, sum, acc_add;
  logic                    ovf, sat_add, accept;

  op_pair_t                wr_pair, head;
  logic                    push, pop;
  logic                    fifo_full, fifo_empty;
  logic [FC_W-1:0]         fifo_cnt, fifo_cnt_n;

  assign wr_pair = '{a: in_a, b: in_b};
  assign push    = in_valid && in_ready && !fifo_full;

  operand_fifo #(
    .W     (2 * OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (wr_pair),
    .pop     (pop),
    .rdata_c (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // Next-state, accumulator and registered-output computation.
  always_comb begin
    state_n     = state_q;
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    tcnt_n      = tcnt_q;
    sat_n       = sat_q;
    num1_n      = num1;
    num2_n      = num2;
    dot_n       = dot;
    dot_valid_n = dot_valid;
    dot_sat_n   = dot_sat;
    err_n       = 1'b0;
    pop         = 1'b0;

    ext     = ACC_W'(result);
    sum     = acc_q + ext;
    ovf     = 1'b0;
    acc_add = sum;
`ifdef DOTP_SATURATE_EN
    ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    if (ovf) acc_add = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
    sat_add = sat_q || ovf;
    accept  = num1_ack && num2_ack && result_ack;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !dot_valid) begin
          pop     = 1'b1;
          num1_n  = head.a;
          num2_n  = head.b;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (accept) begin
          if (cnt_q == CNT_W'(LEN - 1)) begin
            dot_n       = acc_add;
            dot_valid_n = 1'b1;
            dot_sat_n   = sat_add;
            acc_n       = '0;
            cnt_n       = '0;
            sat_n       = 1'b0;
            state_n     = HOLD;
          end else begin
            acc_n   = acc_add;
            sat_n   = sat_add;
            cnt_n   = cnt_q + CNT_W'(1);
            state_n = IDLE;
          end
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          // Abandon the partial dot; remaining queued pairs start a fresh one.
          err_n   = 1'b1;
          acc_n   = '0;
          cnt_n   = '0;
          sat_n   = 1'b0;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt_q + TO_W'(1);
        end
      end
      HOLD: begin
        if (dot_ready) begin
          dot_valid_n = 1'b0;
          dot_sat_n   = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    stb_n      = (state_n == ISSUE);
    fifo_cnt_n = fifo_cnt + FC_W'(push) - FC_W'(pop);
    in_ready_n = (fifo_cnt_n != FC_W'(DEPTH));
    busy_n     = (state_n != IDLE) || (fifo_cnt_n != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      sat_q       <= 1'b0;
      num1        <= '0;
      num2        <= '0;
      num1_stb    <= 1'b0;
      num2_stb    <= 1'b0;
      dot         <= '0;
      dot_valid   <= 1'b0;
      dot_sat     <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      state_q     <= state_n;
      acc_q       <= acc_n;
      cnt_q       <= cnt_n;
      tcnt_q      <= tcnt_n;
      sat_q       <= sat_n;
      num1        <= num1_n;
      num2        <= num2_n;
      num1_stb    <= stb_n;
      num2_stb    <= stb_n;
      dot         <= dot_n;
      dot_valid   <= dot_valid_n;
      dot_sat     <= dot_sat_n;
      err_timeout <= err_n;
      busy        <= busy_n;
      in_ready    <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_matmul_dot_issuer.sv
// Directed, table-driven bench for matmul_dot_issuer with a one-cycle-latency multiplier responder.
module tb_matmul_dot_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main lane (ACC_W=40)
  logic signed [15:0] in_a = '0, in_b = '0;
  logic               in_valid = 1'b0, in_ready;
  logic signed [15:0] num1, num2;
  logic               num1_stb, num2_stb;
  logic               num1_ack = 1'b0, num2_ack = 1'b0, result_ack = 1'b0;
  logic signed [31:0] result = '0;
  logic signed [39:0] dot;
  logic               dot_valid, dot_ready = 1'b0, dot_sat, err_timeout, busy;

  // Saturation lane (ACC_W=32)
  logic signed [15:0] in_a_s = '0, in_b_s = '0;
  logic               in_valid_s = 1'b0, in_ready_s;
  logic signed [15:0] num1_s, num2_s;
  logic               num1_stb_s, num2_stb_s;
  logic               ack_s = 1'b0;
  logic signed [31:0] result_s = '0;
  logic signed [31:0] dot_s;
  logic               dot_valid_s, dot_ready_s = 1'b0, dot_sat_s, err_timeout_s, busy_s;

  matmul_dot_issuer #(.LEN(4), .DEPTH(4), .ACC_W(40), .TIMEOUT(15)) u_dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .num1_stb(num1_stb), .num2_stb(num2_stb),
    .num1_ack(num1_ack), .num2_ack(num2_ack), .result_ack(result_ack), .result(result),
    .dot(dot), .dot_valid(dot_valid), .dot_ready(dot_ready), .dot_sat(dot_sat),
    .err_timeout(err_timeout), .busy(busy)
  );

  matmul_dot_issuer #(.LEN(4), .DEPTH(4), .ACC_W(32), .TIMEOUT(15)) u_sat (
    .clk(clk), .rst(rst), .in_a(in_a_s), .in_b(in_b_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .num1(num1_s), .num2(num2_s), .num1_stb(num1_stb_s), .num2_stb(num2_stb_s),
    .num1_ack(ack_s), .num2_ack(ack_s), .result_ack(ack_s), .result(result_s),
    .dot(dot_s), .dot_valid(dot_valid_s), .dot_ready(dot_ready_s), .dot_sat(dot_sat_s),
    .err_timeout(err_timeout_s), .busy(busy_s)
  );

`ifdef DOTP_SATURATE_EN
  localparam longint SAT_DOT  = 64'sd2147483647;
  localparam longint SAT_FLAG = 1;
`else
  localparam longint SAT_DOT  = 0;
  localparam longint SAT_FLAG = 0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Multiplier model: acks one cycle after a strobe; manual mode lets the bench drive acks directly.
  logic               resp_en = 1'b1, manual = 1'b0, man_ack = 1'b0;
  logic signed [31:0] man_res = '0;
  logic               sp = 1'b0, sp_s = 1'b0;
  logic signed [31:0] rp = '0, rp_s = '0;

  always @(posedge clk) begin
    #1;
    if (manual) begin
      num1_ack = man_ack; num2_ack = man_ack; result_ack = man_ack; result = man_res;
    end else begin
      num1_ack = resp_en && sp; num2_ack = resp_en && sp; result_ack = resp_en && sp;
      result = (resp_en && sp) ? rp : 32'sd0;
    end
    sp = num1_stb;
    rp = num1 * num2;
    ack_s = sp_s;
    result_s = sp_s ? rp_s : 32'sd0;
    sp_s = num1_stb_s;
    rp_s = num1_s * num2_s;
  end

  // Cycle counter and protocol monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int stb_total = 0, ack_total = 0, viol = 0, last_ack_cyc = 0, last_stb_cyc = 0;
  int dv_rise_cyc = 0, err_cyc = 0;
  logic prev_stb = 1'b0, prev_dv = 1'b0;
  always @(negedge clk) begin
    if (num1_stb) begin stb_total++; last_stb_cyc = cyc; end
    if (num1_stb && prev_stb) viol++;
    if (num1_stb != num2_stb) viol++;
    prev_stb = num1_stb;
    if (num1_ack && num2_ack && result_ack) begin ack_total++; last_ack_cyc = cyc; end
    if (dot_valid && !prev_dv) dv_rise_cyc = cyc;
    prev_dv = dot_valid;
    if (err_timeout) err_cyc = cyc;
  end

  typedef struct packed {
    logic [3:0][15:0]   a;
    logic [3:0][15:0]   b;
    logic signed [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input int a0, b0, a1, b1, a2, b2, a3, b3, input longint e);
    vec_t v;
    v.a[0] = 16'(a0); v.b[0] = 16'(b0);
    v.a[1] = 16'(a1); v.b[1] = 16'(b1);
    v.a[2] = 16'(a2); v.b[2] = 16'(b2);
    v.a[3] = 16'(a3); v.b[3] = 16'(b3);
    v.exp  = e;
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting clock edge.
  task automatic push(input logic signed [15:0] a, input logic signed [15:0] b);
    bit ok;
    bit done = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      ok = in_ready;
      @(negedge clk);
      if (ok) done = 1'b1;
    end
    if (!done) chk("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic finish_dot(input string nm, input logic signed [63:0] exp, input int base, input bit accept);
    bit got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (dot_valid) got = 1'b1;
    end
    #1;
    chk({nm, "_valid"}, 64'(got), 1);
    chk({nm, "_dot"}, dot, exp);
    chk({nm, "_sat"}, 64'(dot_sat), 0);
    chk({nm, "_strobes"}, stb_total - base, 4);
    chk({nm, "_dv_latency"}, dv_rise_cyc - last_ack_cyc, 1);
    if (accept) begin
      @(negedge clk); dot_ready = 1'b1;
      @(negedge clk); dot_ready = 1'b0;
      chk({nm, "_cleared"}, 64'(dot_valid), 0);
    end
  endtask

  task automatic run_vec(input int idx, input int start_j, input int base);
    for (int j = start_j; j < 4; j++) push(vecs[idx].a[j], vecs[idx].b[j]);
    finish_dot($sformatf("vec%0d", idx), vecs[idx].exp, base, 1'b1);
  endtask

  initial begin
    int base, k, acc_cnt, a0;
    bit got;
    logic signed [63:0] held;

    vecs[0] = mk(1, 2, 3, 4, -5, 6, 7, -8, -72);
    vecs[1] = mk(2, 2, 2, 2, 2, 2, 2, 2, 16);
    vecs[2] = mk(1, 1, 1, 1, 1, 1, 1, 1, 4);
    vecs[3] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 64'sd4294967296);
    vecs[4] = mk(32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768, -64'sd4294836224);
    vecs[5] = mk(100, -3, 0, 5, -7, -9, 12, 12, -93);
    vecs[6] = mk(3, 3, 1, -1, 2, 5, -4, 4, 2);
    vecs[7] = mk(6, 7, 6, 7, 6, 7, 6, 7, 168);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_stb", 64'(num1_stb), 0);
    chk("rst_dot", dot, 0);
    chk("rst_dot_valid", 64'(dot_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err_timeout), 0);
    chk("rst_num1", num1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 1);

    // Basic dot with first-pair latency
    base = stb_total;
    push(vecs[0].a[0], vecs[0].b[0]);
    chk("lat_idle_stb", 64'(num1_stb), 0);
    chk("lat_idle_busy", 64'(busy), 1);
    @(negedge clk);
    chk("lat_issue_stb", 64'(num1_stb), 1);
    chk("lat_issue_num1", num1, 1);
    chk("lat_issue_num2", num2, 2);
    @(negedge clk);
    chk("lat_wait_stb", 64'(num1_stb), 0);
    run_vec(0, 1, base);

    // Table-driven vectors
    for (int i = 1; i <= 5; i++) run_vec(i, 0, stb_total);

    // Output backpressure: pending dot, FIFO fills, extra pushes rejected
    base = stb_total;
    for (int j = 0; j < 4; j++) push(vecs[5].a[j], vecs[5].b[j]);
    finish_dot("bp_first", vecs[5].exp, base, 1'b0);
    @(negedge clk);
    base = stb_total;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin in_a = 16'(vecs[6].a[i]); in_b = 16'(vecs[6].b[i]); end
      else begin in_a = 16'sd9; in_b = 16'sd9; end
      in_valid = 1'b1;
      if (in_ready) acc_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_accepted", acc_cnt, 4);
    chk("bp_in_ready", 64'(in_ready), 0);
    chk("bp_dot_held", dot, -93);
    chk("bp_dot_valid", 64'(dot_valid), 1);
    chk("bp_no_strobe", stb_total - base, 0);
    dot_ready = 1'b1;
    @(negedge clk);
    dot_ready = 1'b0;
    chk("bp_released", 64'(dot_valid), 0);
    finish_dot("bp_next", vecs[6].exp, base, 1'b1);

    // Timeout: responder silent
    resp_en = 1'b0;
    push(16'sd5, 16'sd5);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (err_timeout) got = 1'b1;
    end
    #1;
    chk("to_pulse_seen", 64'(got), 1);
    chk("to_latency", err_cyc - last_stb_cyc, 16);
    chk("to_no_dot", 64'(dot_valid), 0);
    @(negedge clk);
    chk("to_pulse_width", 64'(err_timeout), 0);
    chk("to_idle", 64'(busy), 0);
    resp_en = 1'b1;
    run_vec(1, 0, stb_total);

    // Saturation lane (ACC_W=32)
    for (int j = 0; j < 4; j++) begin
      in_a_s = -16'sd32768; in_b_s = -16'sd32768; in_valid_s = 1'b1;
      @(negedge clk);
    end
    in_valid_s = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (dot_valid_s) got = 1'b1;
    end
    chk("sat_valid", 64'(got), 1);
    chk("sat_dot", dot_s, SAT_DOT);
    chk("sat_flag", 64'(dot_sat_s), SAT_FLAG);
    dot_ready_s = 1'b1;
    @(negedge clk);
    dot_ready_s = 1'b0;
    chk("sat_flag_cleared", 64'(dot_sat_s), 0);

    // Reset in WAIT after two accepts
    a0 = ack_total;
    for (int j = 0; j < 4; j++) push(16'sd5, 16'sd5);
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      if (num1_stb && (ack_total - a0) == 2) got = 1'b1;
      else @(negedge clk);
    end
    chk("rm_reached_third", 64'(got), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_in_ready", 64'(in_ready), 0);
    chk("rm_stb", 64'(num1_stb), 0);
    chk("rm_busy", 64'(busy), 0);
    chk("rm_num1", num1, 0);
    chk("rm_dot_valid", 64'(dot_valid), 0);
    @(negedge clk);
    chk("rm_in_ready_back", 64'(in_ready), 1);
    chk("rm_fifo_empty", 64'(busy), 0);
    run_vec(2, 0, stb_total);

    // Stale ack in ISSUE, silence, then one proper ack
    base = stb_total;
    manual = 1'b1;
    push(16'sd6, 16'sd7);
    man_ack = 1'b1; man_res = 32'sd42;
    @(negedge clk);
    chk("stale_issue_stb", 64'(num1_stb), 1);
    chk("stale_issue_num1", num1, 6);
    man_ack = 1'b0; man_res = 32'sd0;
    @(negedge clk);
    @(negedge clk);
    chk("stale_still_wait", 64'(busy), 1);
    chk("stale_no_restrobe", 64'(num1_stb), 0);
    man_ack = 1'b1; man_res = 32'sd42;
    @(negedge clk);
    man_ack = 1'b0; man_res = 32'sd0;
    @(negedge clk);
    manual = 1'b0;
    k = 1;
    while (k < 4) begin push(16'sd6, 16'sd7); k++; end
    finish_dot("stale", vecs[7].exp, base, 1'b1);

    chk("strobe_shape", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_dot_issuer.md
# matmul_dot_issuer

Initiator side of the multiplier stb/ack operand protocol. Buffers signed 16-bit operand pairs in a small FIFO and issues them one at a time to a multiplier. Collects each 32-bit product on `result_ack` and accumulates `LEN` products into one dot-product result per output handshake. One instance drives one multiplier lane of the parallel matrix-multiply datapath.

## Interface
Clock is `clk`. Reset is `rst`, synchronous, active-high.

Parameters:
- `LEN`, 4: products per dot result; must be ≥ 1.
- `DEPTH`, 4: operand FIFO entries; power of 2, ≥ 2.
- `ACC_W`, 40: accumulator/result width; must be ≥ 32.
- `TIMEOUT`, 15: WAIT cycles without ack before abort; must be ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `in_a` in 16: signed operand A.
- `in_b` in 16: signed operand B.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO not full.
- `num1` out 16: signed operand to multiplier (registered).
- `num2` out 16: signed operand to multiplier (registered).
- `num1_stb` out 1: operand strobe, high only in ISSUE.
- `num2_stb` out 1: identical to `num1_stb`.
- `num1_ack` in 1: multiplier ack.
- `num2_ack` in 1: multiplier ack.
- `result_ack` in 1: product valid.
- `result` in 32: signed product.
- `dot` out ACC_W: signed dot-product result.
- `dot_valid` out 1: `dot` valid, held until accepted.
- `dot_ready` in 1: consumer accepts `dot`.
- `dot_sat` out 1: saturation occurred in this dot; always 0 without the macro.
- `err_timeout` out 1: one-cycle pulse on ack timeout.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.

## Operation
- **Reset:** all outputs 0 (`in_ready` is 0 during reset, 1 the cycle after), FIFO empty, accumulator 0, product count 0, state IDLE.
- **FIFO push:** on `in_valid && in_ready`. `in_ready = !full`. A push attempted while full is ignored and never overwrites an entry.
- **IDLE:** if FIFO is non-empty and `!dot_valid`, pop the head into `num1`/`num2` and go to ISSUE. Otherwise stay. No issue occurs while a result is pending.
- **ISSUE:** `num1_stb = num2_stb = 1` for exactly one cycle, then go to WAIT. Any ack inputs seen in ISSUE are stale and ignored.
- **WAIT:** strobes are 0.
  - Accept when `num1_ack && num2_ack && result_ack`. Add the sign-extended `result` to the accumulator.
  - If count == LEN−1: load `dot` with the new sum, set `dot_valid`, clear accumulator and count, go to HOLD.
  - Otherwise: count++ and go to IDLE.
  - Timeout counter is cleared on entry and increments each WAIT cycle without an accept. When it reaches TIMEOUT:
    - pulse `err_timeout`;
    - discard the partial accumulator and count;
    - go to IDLE. Pairs already issued for that dot are lost; remaining FIFO pairs start a new dot.
- **HOLD:** `dot`, `dot_valid` and `dot_sat` are stable until `dot_ready`. On acceptance, clear `dot_valid` and `dot_sat` at that edge and go to IDLE.
- **Arithmetic:** the 32-bit product is sign-extended to ACC_W. Without the macro, the sum wraps modulo 2^ACC_W.

## Timing
- One product every 3 cycles (IDLE, ISSUE, WAIT) with an ack one cycle after the strobe, which is the standard multiplier response.
- A pair pushed at edge k is popped in IDLE in cycle k+1. Strobe is high in cycle k+2; accept happens at the end of cycle k+3.
- `dot_valid` rises in the cycle after the LEN-th accept.
- A strobe is never high in two consecutive cycles.
- Simultaneous push and pop are allowed when the FIFO is neither empty nor full. FIFO count is unchanged.
- Reset mid-operation clears everything at the next edge. Strobes are 0 in the following cycle, and a late ack arriving after reset is ignored in IDLE.

## Configuration
Macro `DOTP_SATURATE_EN`:
- **Defined:** each accumulation clamps to the signed ACC_W max/min on overflow, and `dot_sat` latches 1 for that dot.
- **Undefined:** the sum wraps and `dot_sat` is tied 0.

## Structure
- **Package `matmul_pkg`:** `OP_W=16`, `PROD_W=32`, and the state enum (IDLE, ISSUE, WAIT, HOLD).
- **Sub-module `operand_fifo`:** a parameterised synchronous FIFO (data = 2×OP_W, DEPTH, full/empty). It is natural to split out and is reusable by other lanes.
- The FSM, accumulator and timeout counter stay in the top module.

## Test plan
1. **Basic dot:** LEN=4, pairs (1,2),(3,4),(−5,6),(7,−8) → `dot` = −72. `dot_valid` rises the cycle after the 4th accept; exactly 4 single-cycle strobe pulses.
2. **Output backpressure:** hold `dot_ready` = 0 for 10 cycles while pushing 6 pairs.
   - `dot` stays stable and no strobes fire.
   - FIFO fills to 4 and `in_ready` = 0; extra pushes are rejected.
   - After `dot_ready`, the next dot is computed correctly.
3. **Timeout:** responder never acks → `err_timeout` pulses after 15 WAIT cycles and no `dot_valid`. The next 4 pairs (2,2)×4 with normal acks → `dot` = 16.
4. **Saturation:** ACC_W=32, pairs (−32768,−32768)×4.
   - With `DOTP_SATURATE_EN`: `dot` = 2147483647, `dot_sat` = 1.
   - Without it: `dot` = 0, `dot_sat` = 0.
5. **Reset mid-dot:** assert `rst` in WAIT after 2 accepts → all outputs 0 next cycle, FIFO empty. The next pairs (1,1)×4 → `dot` = 4.
6. **Stale ack:** `result_ack` is held 1 during ISSUE, then 0 in WAIT → no accumulate. A proper ack 2 cycles later is accepted once.
